// File: rtl/adc_pkg.sv
// ADC frame demux shared definitions: FSM encoding, frame field positions, 2C->offset-binary helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KICK  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } adc_state_t;

    // Frame layout: [15] ignored, [14:13] channel ID, [12:0] two's-complement sample
    localparam int FRAME_ID_HI = 14;
    localparam int FRAME_ID_LO = 13;
    localparam int FRAME_MSB   = 12;

    // Flipping the sign bit is the same as adding 2^12 to a 13-bit 2C value
    function automatic logic [12:0] offset_bin(input logic [12:0] s);
        return {~s[12], s[11:0]};
    endfunction

endpackage

// File: rtl/adc_ch_accum.sv
// Per-channel averager: sums 2^AVG_LOG2 results, publishes the truncated mean with a one-cycle strobe.
// Latency: result and strobe registered on the edge that accepts the final sample.
// Backpressure: none; wr is accepted every cycle, clr discards a partial sum.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          drop partial sum and sample count
//   wr, din      one result of M bits to accumulate
//   dout, vld    averaged result and its update strobe
module adc_ch_accum #(
    parameter int M        = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr,
    input  logic [M-1:0] din,
    output logic [M-1:0] dout,
    output logic         vld
);
    localparam int AW = M + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [M-1:0]  dout_q;
    logic          vld_q;
    logic [AW-1:0] sum_next;
    logic [AW-1:0] mean;

    assign sum_next = acc_q + AW'(din);
    assign mean     = sum_next >> AVG_LOG2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (clr) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (wr) begin
                if (cnt_q == LAST) begin
                    dout_q <= mean[M-1:0];
                    vld_q  <= 1'b1;
                    acc_q  <= '0;
                    cnt_q  <= '0;
                end else begin
                    acc_q <= sum_next;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign dout = dout_q;
    assign vld  = vld_q;

endmodule

// File: rtl/adc_frame_demux.sv
// ADC readout demux: kicks SPI conversions, decodes channel frames to M-bit offset binary, checks ID order and timeouts.
// Latency: frame sampled at edge t+1 (driven after edge t) -> CH_DATA / CH_VLD updated at edge t+2.
// Backpressure: none; frames outside WAIT are dropped and flagged with OVR, missing frames re-kick after TIMEOUT_CYC.
//
// Ports:
//   CLK20M, RSTn          clock, synchronous active-low reset
//   EN                    run enable (low forces IDLE)
//   FRAME_VLD, FRAME_DATA incoming 16-bit frame and its strobe
//   HOLD                  conversion kick pulse
//   CH_DATA, CH_VLD       packed per-channel results (channel k at [k*M +: M]) and update strobes
//   SEQ_ERR, TIMEOUT, OVR status pulses
// Build option: ADC_AVG_EN enables per-channel averaging of 2^AVG_LOG2 samples.
module adc_frame_demux
    import adc_pkg::*;
#(
    parameter int M           = 12,
    parameter int NCH         = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int AVG_LOG2    = 2
) (
    input  logic             CLK20M,
    input  logic             RSTn,
    input  logic             EN,
    input  logic             FRAME_VLD,
    input  logic [15:0]      FRAME_DATA,
    output logic             HOLD,
    output logic [NCH*M-1:0] CH_DATA,
    output logic [NCH-1:0]   CH_VLD,
    output logic             SEQ_ERR,
    output logic             TIMEOUT,
    output logic             OVR
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    NCH_W      = 3'(NCH);
    localparam logic [1:0]    ID_LAST    = 2'(NCH - 1);

    adc_state_t    state_q;
    logic [TW-1:0] timer_q;
    logic [14:0]   frame_q;
    logic [1:0]    exp_id_q;
    logic          hold_q;
    logic          seq_err_q;
    logic          timeout_q;
    logic          ovr_q;

    logic [1:0]     frame_id;
    logic [12:0]    ob;
    logic [M-1:0]   res;
    logic           id_ok;
    logic           store_go;
    logic [NCH-1:0] wr_sel;
    logic           unused_ok;

    assign frame_id = frame_q[FRAME_ID_HI:FRAME_ID_LO];
    assign ob       = offset_bin(frame_q[FRAME_MSB:0]);
    assign res      = ob[FRAME_MSB -: M];
    assign id_ok    = ({1'b0, frame_id} < NCH_W);
    // A frame sitting in STORE when EN drops is thrown away
    assign store_go = (state_q == ST_STORE) && EN;

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_sel[k] = store_go && id_ok && (frame_id == 2'(k));
        end
    end

    always_ff @(posedge CLK20M) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            frame_q   <= '0;
            exp_id_q  <= '0;
            hold_q    <= 1'b0;
            seq_err_q <= 1'b0;
            timeout_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            hold_q    <= 1'b0;
            seq_err_q <= 1'b0;
            timeout_q <= 1'b0;
            ovr_q     <= 1'b0;

            // Dropped-frame flag depends only on the current state, not on EN
            if (FRAME_VLD && (state_q != ST_WAIT)) begin
                ovr_q <= 1'b1;
            end

            if (!EN) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_KICK;
                    end
                    ST_KICK: begin
                        // HOLD is registered here, so it is seen in the first WAIT cycle
                        hold_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // A frame wins over a timeout expiring on the same edge
                        if (FRAME_VLD) begin
                            frame_q <= FRAME_DATA[14:0];
                            state_q <= ST_STORE;
                        end else if (timer_q == TIMER_LAST) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_KICK;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    ST_STORE: begin
                        if (!id_ok) begin
                            seq_err_q <= 1'b1;
                        end else begin
                            if (frame_id != exp_id_q) begin
                                seq_err_q <= 1'b1;
                            end
                            exp_id_q <= (frame_id == ID_LAST) ? 2'd0 : frame_id + 2'd1;
                        end
                        state_q <= ST_WAIT;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign HOLD    = hold_q;
    assign SEQ_ERR = seq_err_q;
    assign TIMEOUT = timeout_q;
    assign OVR     = ovr_q;

`ifdef ADC_AVG_EN
    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_acc
            adc_ch_accum #(
                .M        (M),
                .AVG_LOG2 (AVG_LOG2)
            ) u_acc (
                .clk   (CLK20M),
                .rst_n (RSTn),
                .clr   (~EN),
                .wr    (wr_sel[k]),
                .din   (res),
                .dout  (CH_DATA[k*M +: M]),
                .vld   (CH_VLD[k])
            );
        end
    endgenerate

    assign unused_ok = &{1'b0, FRAME_DATA[15]};
`else
    logic [NCH*M-1:0] ch_data_q;
    logic [NCH-1:0]   ch_vld_q;

    always_ff @(posedge CLK20M) begin
        if (!RSTn) begin
            ch_data_q <= '0;
            ch_vld_q  <= '0;
        end else begin
            ch_vld_q <= wr_sel;
            for (int c = 0; c < NCH; c++) begin
                if (wr_sel[c]) begin
                    ch_data_q[c*M +: M] <= res;
                end
            end
        end
    end

    assign CH_DATA   = ch_data_q;
    assign CH_VLD    = ch_vld_q;
    assign unused_ok = &{1'b0, FRAME_DATA[15], 32'(AVG_LOG2)};
`endif

endmodule

// File: tb/tb_adc_frame_demux.sv
// Directed bench for adc_frame_demux: reset, conversion, sequence check, timeout, overrun, optional averaging.
// Two instances: default (NCH=4) and a three-channel variant for the invalid-ID case.
// Inputs driven and outputs sampled 1 ns after the rising edge.
module tb_adc_frame_demux;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        fv;
    logic [15:0] fd;
    logic        fv2;
    logic [15:0] fd2;

    logic        hold, seq_err, timeout, ovr;
    logic [47:0] ch_data;
    logic [3:0]  ch_vld;
    logic        hold2, seq_err2, timeout2, ovr2;
    logic [35:0] ch_data2;
    logic [2:0]  ch_vld2;

    int vectors = 0;
    int miscompares = 0;

    always #25 clk = ~clk;

    adc_frame_demux #(.M(12), .NCH(4), .TIMEOUT_CYC(64), .AVG_LOG2(2)) dut (
        .CLK20M     (clk),
        .RSTn       (rstn),
        .EN         (en),
        .FRAME_VLD  (fv),
        .FRAME_DATA (fd),
        .HOLD       (hold),
        .CH_DATA    (ch_data),
        .CH_VLD     (ch_vld),
        .SEQ_ERR    (seq_err),
        .TIMEOUT    (timeout),
        .OVR        (ovr)
    );

    adc_frame_demux #(.M(12), .NCH(3), .TIMEOUT_CYC(64), .AVG_LOG2(2)) dut3 (
        .CLK20M     (clk),
        .RSTn       (rstn),
        .EN         (en),
        .FRAME_VLD  (fv2),
        .FRAME_DATA (fd2),
        .HOLD       (hold2),
        .CH_DATA    (ch_data2),
        .CH_VLD     (ch_vld2),
        .SEQ_ERR    (seq_err2),
        .TIMEOUT    (timeout2),
        .OVR        (ovr2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Restart both instances: IDLE -> KICK -> WAIT; returns in the HOLD cycle with timer at 0
    task automatic kick();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
    endtask

    // Frame is sampled on the first edge, written on the second; returns just after the write edge
    task automatic send_frame(input bit sel, input logic [15:0] d);
        if (sel) begin fv2 = 1'b1; fd2 = d; end
        else     begin fv  = 1'b1; fd  = d; end
        step();
        fv  = 1'b0;
        fv2 = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0;
        step();
        step();
        vectors++;
        if (ch_data !== 48'h0 || ch_vld !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_ch: data=%h vld=%h expected 0/0", ch_data, ch_vld);
        end
        vectors++;
        if ({hold, seq_err, timeout, ovr} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: hold/seq/to/ovr=%b expected 0000", {hold, seq_err, timeout, ovr});
        end
        vectors++;
        if (ch_data2 !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_ch3: data=%h expected 0", ch_data2);
        end
        rstn = 1'b1; en = 1'b1;
        step();
        vectors++;
        if (hold !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_kick_cycle: hold=%b expected 0", hold);
        end
        step();
        vectors++;
        if (hold !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_pulse: hold=%b expected 1", hold);
        end
        step();
        vectors++;
        if (hold !== 1'b0 || ch_vld !== 4'h0 || ch_data !== 48'h0) begin
            miscompares++;
            $display("FAIL hold_after: hold=%b vld=%h data=%h expected 0/0/0", hold, ch_vld, ch_data);
        end
    endtask

    task automatic test_sequence();
        logic [15:0] dat [7] = '{16'h0123, 16'h2456, 16'h4789, 16'h7ABC, 16'h0001, 16'h4000, 16'h6FFE};
        int          chn [7] = '{0, 1, 2, 3, 0, 2, 3};
        logic [11:0] res [7] = '{12'h891, 12'hA2B, 12'hBC4, 12'h55E, 12'h800, 12'h800, 12'hFFF};
        logic        err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        kick();
        for (int i = 0; i < 7; i++) begin
            send_frame(1'b0, dat[i]);
            vectors++;
            if (ch_vld !== 4'(1 << chn[i]) || ch_data[chn[i]*12 +: 12] !== res[i]) begin
                miscompares++;
                $display("FAIL seq_write[%0d]: vld=%h data=%h expected vld=%h data=%h",
                         i, ch_vld, ch_data[chn[i]*12 +: 12], 4'(1 << chn[i]), res[i]);
            end
            vectors++;
            if (seq_err !== err[i]) begin
                miscompares++;
                $display("FAIL seq_err[%0d]: seq_err=%b expected %b", i, seq_err, err[i]);
            end
        end
    endtask

    task automatic test_conversion();
        kick();
        fv = 1'b1; fd = 16'h0000;
        step();
        fv = 1'b0;
        vectors++;
        if (ch_vld !== 4'h0) begin
            miscompares++;
            $display("FAIL latency_early: vld=%h expected 0 one edge after sampling", ch_vld);
        end
        step();
        vectors++;
        if (ch_vld !== 4'b0001 || ch_data[11:0] !== 12'h800) begin
            miscompares++;
            $display("FAIL conv_zero: vld=%h data=%h expected 1/800", ch_vld, ch_data[11:0]);
        end
        send_frame(1'b0, 16'h1FFF);
        vectors++;
        if (ch_vld !== 4'b0001 || ch_data[11:0] !== 12'h7FF) begin
            miscompares++;
            $display("FAIL conv_minus1: vld=%h data=%h expected 1/7ff", ch_vld, ch_data[11:0]);
        end
        send_frame(1'b0, 16'h0FFF);
        vectors++;
        if (ch_vld !== 4'b0001 || ch_data[11:0] !== 12'hFFF) begin
            miscompares++;
            $display("FAIL conv_max: vld=%h data=%h expected 1/fff", ch_vld, ch_data[11:0]);
        end
    endtask

    task automatic test_invalid_id();
        kick();
        send_frame(1'b1, 16'h0000);
        vectors++;
        if (ch_vld2 !== 3'b001 || ch_data2 !== 36'h000_000_800 || seq_err2 !== 1'b0) begin
            miscompares++;
            $display("FAIL nch3_ch0: vld=%h data=%h err=%b expected 1/000000800/0", ch_vld2, ch_data2, seq_err2);
        end
        send_frame(1'b1, 16'h6123);
        vectors++;
        if (ch_vld2 !== 3'b000 || ch_data2 !== 36'h000_000_800 || seq_err2 !== 1'b1) begin
            miscompares++;
            $display("FAIL nch3_id3: vld=%h data=%h err=%b expected 0/000000800/1", ch_vld2, ch_data2, seq_err2);
        end
        send_frame(1'b1, 16'h2000);
        vectors++;
        if (ch_vld2 !== 3'b010 || ch_data2 !== 36'h000_800_800 || seq_err2 !== 1'b0) begin
            miscompares++;
            $display("FAIL nch3_expected_kept: vld=%h data=%h err=%b expected 2/000800800/0", ch_vld2, ch_data2, seq_err2);
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        kick();
        for (int i = 0; i < 63; i++) begin
            step();
            if (timeout !== 1'b0 || hold !== 1'b0) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL timeout_early: %0d cycles with timeout/hold set, expected 0", early);
        end
        step();
        vectors++;
        if (timeout !== 1'b1 || hold !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: timeout=%b hold=%b expected 1/0", timeout, hold);
        end
        step();
        vectors++;
        if (timeout !== 1'b0 || hold !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rekick: timeout=%b hold=%b expected 0/1", timeout, hold);
        end
        for (int i = 0; i < 63; i++) step();
        fv = 1'b1; fd = 16'h2000;
        step();
        fv = 1'b0;
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_last_cycle_frame: timeout=%b expected 0", timeout);
        end
        step();
        vectors++;
        if (timeout !== 1'b0 || ch_vld !== 4'b0010 || ch_data[23:12] !== 12'h800) begin
            miscompares++;
            $display("FAIL timeout_frame_store: timeout=%b vld=%h data=%h expected 0/2/800",
                     timeout, ch_vld, ch_data[23:12]);
        end
    endtask

    task automatic test_overrun();
        kick();
        fv = 1'b1; fd = 16'h4100;
        step();
        fd = 16'h6200;
        step();
        fv = 1'b0;
        vectors++;
        if (ovr !== 1'b1 || ch_vld !== 4'b0100 || ch_data[35:24] !== 12'h880) begin
            miscompares++;
            $display("FAIL ovr_in_store: ovr=%b vld=%h data=%h expected 1/4/880", ovr, ch_vld, ch_data[35:24]);
        end
        step();
        vectors++;
        if (ovr !== 1'b0 || ch_vld !== 4'h0 || ch_data[47:36] !== 12'hFFF) begin
            miscompares++;
            $display("FAIL ovr_dropped: ovr=%b vld=%h ch3=%h expected 0/0/fff", ovr, ch_vld, ch_data[47:36]);
        end
        en = 1'b0;
        step();
        fv = 1'b1; fd = 16'h6000;
        step();
        fv = 1'b0;
        vectors++;
        if (ovr !== 1'b1 || ch_vld !== 4'h0) begin
            miscompares++;
            $display("FAIL ovr_idle: ovr=%b vld=%h expected 1/0", ovr, ch_vld);
        end
        step();
        vectors++;
        if (ch_data !== {12'hFFF, 12'h880, 12'h800, 12'hFFF} || ch_vld !== 4'h0) begin
            miscompares++;
            $display("FAIL hold_data_idle: data=%h vld=%h expected fff880800fff/0", ch_data, ch_vld);
        end
    endtask

    task automatic test_avg();
        logic [15:0] dat [4] = '{16'h3200, 16'h3204, 16'h3208, 16'h320C};
        int          early = 0;
        kick();
        for (int i = 0; i < 3; i++) begin
            send_frame(1'b0, dat[i]);
            if (ch_vld !== 4'h0) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL avg_intermediate: %0d strobes, expected 0", early);
        end
        send_frame(1'b0, dat[3]);
        vectors++;
        if (ch_vld !== 4'b0010 || ch_data[23:12] !== 12'h103) begin
            miscompares++;
            $display("FAIL avg_result: vld=%h data=%h expected 2/103", ch_vld, ch_data[23:12]);
        end
        step();
        vectors++;
        if (ch_vld !== 4'h0 || ch_data[23:12] !== 12'h103) begin
            miscompares++;
            $display("FAIL avg_hold: vld=%h data=%h expected 0/103", ch_vld, ch_data[23:12]);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0;
        fv = 1'b0; fd = 16'h0;
        fv2 = 1'b0; fd2 = 16'h0;
        test_reset();
`ifdef ADC_AVG_EN
        test_avg();
`else
        test_sequence();
        test_conversion();
        test_invalid_id();
        test_timeout();
        test_overrun();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
